// File: rtl/serializer_gearbox.sv
// serializer_gearbox: multi-channel parallel-to-serial gearbox.
// Takes one WIDTH-bit word per channel through a valid/ready handshake and
// emits OUT_BITS bits per channel every clock, with no gaps between words.
// When no word is available, IDLE_WORD is loaded into every channel.
// Optional build macro: SERIALIZER_MSB_FIRST_EN (MSB-first slices, left shift);
// when it is not defined the block emits LSB first (TMDS order).
`timescale 1ns/1ps

module serializer_gearbox #(
  parameter int unsigned      CHANNELS  = 3,
  parameter int unsigned      WIDTH     = 10,
  parameter int unsigned      OUT_BITS  = 1,
  parameter logic [WIDTH-1:0] IDLE_WORD = 10'b1101010100
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [CHANNELS*WIDTH-1:0]    i_data,
  input  logic                         i_valid,
  output logic                         o_ready,
  output logic [CHANNELS*OUT_BITS-1:0] o_data,
  output logic                         o_word_start,
  output logic                         o_underrun,
  input  logic                         i_clear_underrun
);

  localparam int unsigned BEATS = WIDTH / OUT_BITS;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0]          cnt;
  logic [CHANNELS*WIDTH-1:0] hold;
  logic                      hold_full;
  logic [CHANNELS*WIDTH-1:0] shift;
  logic [CHANNELS*WIDTH-1:0] shifted;
  logic                      primed;
  logic                      underrun;
  logic                      word_start;

  logic load;
  logic accept;
  logic idle_load;

  assign load      = (cnt == LAST_BEAT);
  assign o_ready   = !hold_full || load;
  assign accept    = i_valid && o_ready;
  // Idle is loaded only when neither hold nor a bypass word can fill the slot.
  assign idle_load = load && !hold_full && !accept;

  assign o_word_start = word_start;
  assign o_underrun   = underrun;

  // Per-channel shift by one slice; vacated bits fill with zero.
  always_comb begin
    shifted = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
`ifdef SERIALIZER_MSB_FIRST_EN
      shifted[c*WIDTH +: WIDTH] = shift[c*WIDTH +: WIDTH] << OUT_BITS;
`else
      shifted[c*WIDTH +: WIDTH] = shift[c*WIDTH +: WIDTH] >> OUT_BITS;
`endif
    end
  end

  // Present the outgoing slice of every channel.
  always_comb begin
    o_data = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
`ifdef SERIALIZER_MSB_FIRST_EN
      o_data[c*OUT_BITS +: OUT_BITS] = shift[c*WIDTH + WIDTH - OUT_BITS +: OUT_BITS];
`else
      o_data[c*OUT_BITS +: OUT_BITS] = shift[c*WIDTH +: OUT_BITS];
`endif
    end
  end

  // Beat counter, hold register, shift registers and status flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt        <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      shift      <= '0;
      primed     <= 1'b0;
      underrun   <= 1'b0;
      word_start <= 1'b0;
    end else begin
      cnt        <= load ? '0 : cnt + 1'b1;
      word_start <= load;

      if (accept) begin
        primed <= 1'b1;
      end

      if (load) begin
        if (hold_full) begin
          // Hold drains into the shifters; a same-edge word refills hold.
          shift <= hold;
          if (accept) begin
            hold <= i_data;
          end else begin
            hold_full <= 1'b0;
          end
        end else if (accept) begin
          shift <= i_data;
        end else begin
          shift <= {CHANNELS{IDLE_WORD}};
        end
      end else begin
        shift <= shifted;
        if (accept) begin
          hold      <= i_data;
          hold_full <= 1'b1;
        end
      end

      // Setting wins over a simultaneous clear.
      if (idle_load && primed) begin
        underrun <= 1'b1;
      end else if (i_clear_underrun) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serializer_gearbox.sv
// Directed self-checking bench for serializer_gearbox (3 channels, 10-bit
// words, 1-bit slices) plus a 2-bit-slice gearbox instance.
`timescale 1ns/1ps

module tb_serializer_gearbox;

  localparam int unsigned CH = 3;
  localparam int unsigned W  = 10;
  localparam logic [W-1:0] IDLE = 10'b1101010100;
  localparam logic [CH*W-1:0] IDLE3 = {IDLE, IDLE, IDLE};

  localparam logic [CH*W-1:0] WORD_A = {10'b1100000010, 10'b1001011001, 10'b0110100110};
  localparam logic [CH*W-1:0] WORD_B = 30'h2AAA5555;
  localparam logic [CH*W-1:0] WORD_D = 30'h1F0F0F0F;
  localparam logic [CH*W-1:0] WORD_E = 30'h0333CCCC;
  localparam logic [CH*W-1:0] STREAM [8] = '{
    30'h12345678, 30'h0ABCDEF0, 30'h3FF00FF0, 30'h00000001,
    30'h20000000, 30'h15555555, 30'h0F0F0F0F, 30'h33CC33CC
  };

  logic              clk = 1'b0;
  logic              rst_n, valid, clr;
  logic [CH*W-1:0]   data;
  logic              ready, ws, under;
  logic [CH-1:0]     odata;

  logic              rst2_n, valid2, clr2;
  logic [CH*W-1:0]   data2;
  logic              ready2, ws2, under2;
  logic [CH*2-1:0]   odata2;

  always #5 clk = ~clk;

  serializer_gearbox #(
    .CHANNELS(CH), .WIDTH(W), .OUT_BITS(1), .IDLE_WORD(IDLE)
  ) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid),
    .o_ready(ready), .o_data(odata), .o_word_start(ws),
    .o_underrun(under), .i_clear_underrun(clr)
  );

  serializer_gearbox #(
    .CHANNELS(CH), .WIDTH(W), .OUT_BITS(2), .IDLE_WORD(IDLE)
  ) u_gb (
    .i_clk(clk), .i_rst_n(rst2_n), .i_data(data2), .i_valid(valid2),
    .o_ready(ready2), .o_data(odata2), .o_word_start(ws2),
    .o_underrun(under2), .i_clear_underrun(clr2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int t_cnt    = 0;
  int asm_n    = -1;
  logic [CH*W-1:0] asm_w;
  logic [CH*W-1:0] tx_q [$];
  logic [CH*W-1:0] rx_q [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bit position inside a word carried by beat b (1-bit slices).
  function automatic int bit_pos(input int b);
`ifdef SERIALIZER_MSB_FIRST_EN
    return W - 1 - b;
`else
    return b;
`endif
  endfunction

  // One clock: offer the head of tx_q, then sample #1 after the edge and
  // reassemble words that start on o_word_start.
  task automatic tick();
    logic acc;
    valid = (tx_q.size() > 0);
    data  = valid ? tx_q[0] : '0;
    acc   = valid && ready;
    @(posedge clk);
    #1;
    if (acc) void'(tx_q.pop_front());
    t_cnt++;
    check_eq("word_start", 64'(ws), 64'(t_cnt >= 10 && (t_cnt % 10) == 0));
    if (ws) asm_n = 0;
    if (asm_n >= 0) begin
      for (int c = 0; c < CH; c++) asm_w[c*W + bit_pos(asm_n)] = odata[c];
      asm_n++;
      if (asm_n == W) begin
        rx_q.push_back(asm_w);
        asm_n = -1;
      end
    end
  endtask

  task automatic run_until(input int n);
    while (t_cnt < n) tick();
  endtask

  task automatic check_rx(input string tag, input logic [CH*W-1:0] exp);
    check_eq({tag, "_present"}, 64'(rx_q.size() > 0), 64'd1);
    if (rx_q.size() > 0) check_eq(tag, 64'(rx_q.pop_front()), 64'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CH-1:0] exp_bits;
    logic [1:0]    gb_exp [5];

    rst_n = 1'b0; valid = 1'b0; clr = 1'b0; data = '0;
    rst2_n = 1'b0; valid2 = 1'b0; clr2 = 1'b0; data2 = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_data", 64'(odata), 64'd0);
    check_eq("rst_ready", 64'(ready), 64'd1);
    check_eq("rst_word_start", 64'(ws), 64'd0);
    check_eq("rst_underrun", 64'(under), 64'd0);

    // Startup: first load on the 10th edge is IDLE without underrun
    rst_n = 1'b1;
    t_cnt = 0;
    run_until(5);
    check_eq("pre_load_data", 64'(odata), 64'd0);
    run_until(20);
    check_rx("startup_idle", IDLE3);
    check_eq("startup_underrun", 64'(under), 64'd0);

    // Single word accepted into hold, emitted after the next load edge
    tx_q.push_back(WORD_A);
    run_until(21);
    check_eq("hold_full_ready", 64'(ready), 64'd0);
    run_until(39);
    check_rx("idle_before_a", IDLE3);
    check_rx("word_a", WORD_A);
    check_eq("word_a_underrun", 64'(under), 64'd0);

    // Underrun set, clear, set-wins-over-clear
    run_until(40);
    check_eq("underrun_set", 64'(under), 64'd1);
    clr = 1'b1; run_until(41); clr = 1'b0;
    check_eq("underrun_clear", 64'(under), 64'd0);
    run_until(49);
    check_rx("underrun_idle", IDLE3);
    clr = 1'b1; run_until(50); clr = 1'b0;
    check_eq("set_wins_clear", 64'(under), 64'd1);
    clr = 1'b1; run_until(51); clr = 1'b0;
    check_eq("underrun_clear2", 64'(under), 64'd0);

    // Continuous stream of 8 words
    for (int i = 0; i < 8; i++) tx_q.push_back(STREAM[i]);
    run_until(52);
    check_eq("stream_ready_busy", 64'(ready), 64'd0);
    run_until(59);
    check_eq("stream_ready_load", 64'(ready), 64'd1);
    check_rx("pre_stream_idle", IDLE3);
    run_until(60);
    check_eq("stream_ready_after", 64'(ready), 64'd0);
    run_until(130);
    check_eq("stream_drained_ready", 64'(ready), 64'd1);
    run_until(139);
    for (int i = 0; i < 8; i++) check_rx($sformatf("stream_w%0d", i), STREAM[i]);
    check_eq("stream_underrun", 64'(under), 64'd0);
    run_until(140);
    check_eq("stream_end_underrun", 64'(under), 64'd1);

    // Bypass: word offered on the load cycle with hold empty
    run_until(149);
    check_rx("post_stream_idle", IDLE3);
    tx_q.push_back(WORD_B);
    run_until(150);
    for (int c = 0; c < CH; c++) exp_bits[c] = WORD_B[c*W + bit_pos(0)];
    check_eq("bypass_first_slice", 64'(odata), 64'(exp_bits));
    run_until(159);
    check_rx("bypass_word", WORD_B);

    // Reset mid-word with hold full
    tx_q.push_back(WORD_D);
    tx_q.push_back(WORD_E);
    run_until(164);
    check_eq("mid_hold_full", 64'(ready), 64'd0);
    for (int c = 0; c < CH; c++) exp_bits[c] = WORD_D[c*W + bit_pos(4)];
    check_eq("mid_beat4", 64'(odata), 64'(exp_bits));
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_data", 64'(odata), 64'd0);
    check_eq("async_rst_ready", 64'(ready), 64'd1);
    check_eq("async_rst_ws", 64'(ws), 64'd0);
    check_eq("async_rst_underrun", 64'(under), 64'd0);
    tx_q.delete();
    rx_q.delete();
    asm_n = -1;
    valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    t_cnt = 0;
    run_until(5);
    check_eq("post_rst_data", 64'(odata), 64'd0);
    run_until(20);
    check_rx("post_rst_idle", IDLE3);
    check_eq("post_rst_underrun", 64'(under), 64'd0);

    // Gearbox: 2-bit slices, channel 2 carries 10'b1100000010
`ifdef SERIALIZER_MSB_FIRST_EN
    gb_exp = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b10};
`else
    gb_exp = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b11};
`endif
    check_eq("gb_rst_data", 64'(odata2), 64'd0);
    check_eq("gb_rst_ready", 64'(ready2), 64'd1);
    rst2_n = 1'b1;
    valid2 = 1'b1;
    data2  = {10'b1100000010, 10'b0, 10'b0};
    @(posedge clk); #1;
    valid2 = 1'b0;
    data2  = '0;
    check_eq("gb_hold_ready", 64'(ready2), 64'd0);
    for (int e = 2; e <= 4; e++) begin
      @(posedge clk); #1;
      check_eq($sformatf("gb_pre_ws%0d", e), 64'(ws2), 64'd0);
    end
    for (int b = 0; b < 5; b++) begin
      @(posedge clk); #1;
      check_eq($sformatf("gb_ws%0d", b), 64'(ws2), 64'(b == 0));
      check_eq($sformatf("gb_slice%0d", b), 64'(odata2[5:4]), 64'(gb_exp[b]));
      check_eq($sformatf("gb_low%0d", b), 64'(odata2[3:0]), 64'd0);
    end
    check_eq("gb_underrun", 64'(under2), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serializer_gearbox.md
# serializer_gearbox

Multi-channel, single-clock parallel-to-serial gearbox for the display output path. Accepts one WIDTH-bit word per channel via a valid/ready handshake and emits OUT_BITS bits per channel per clock, with no gaps between consecutive words. It generalises the fixed 10:1 TMDS serializer to any channel count, word width and output slice width. It feeds I/O primitives or a DDR stage, and inserts a programmable idle word on underrun.

## Interface
- `CHANNELS`, default 3: number of parallel lanes.
- `WIDTH`, default 10: parallel word width per channel.
- `OUT_BITS`, default 1: bits emitted per channel per clock. Must divide `WIDTH`. `BEATS = WIDTH/OUT_BITS`, and `BEATS` ≥ 2.
- `IDLE_WORD`, default 10'b1101010100: word loaded into every channel when no data is available.
- `i_clk` in 1: sole clock (bit-slice rate).
- `i_rst_n` in 1: reset. **Asynchronous and active-low.** This is the single clock/reset of the block.
- `i_data` in CHANNELS*WIDTH: channel c occupies `[c*WIDTH +: WIDTH]`.
- `i_valid` in 1: `i_data` is valid.
- `o_ready` out 1: block can take a word this cycle.
- `o_data` out CHANNELS*OUT_BITS: current slice. Channel c occupies `[c*OUT_BITS +: OUT_BITS]`.
- `o_word_start` out 1: `o_data` carries the first slice of a word.
- `o_underrun` out 1: sticky flag; an idle word was inserted after streaming began.
- `i_clear_underrun` in 1: synchronous clear of `o_underrun`.

## Operation
- **State**
  - Beat counter `cnt`, range 0..BEATS-1. It increments every clock and wraps from BEATS-1 to 0.
  - Holding register `hold` with flag `hold_full`.
  - One shift register per channel, WIDTH bits wide.
  - Flag `primed`.
- **Handshake:** a word is accepted on an edge where `i_valid && o_ready`. `o_ready = !hold_full || (cnt == BEATS-1)`. It is combinational from registers only and never depends on `i_valid`.
- **Load edge** (edge with `cnt == BEATS-1`). Each shift register loads from the first matching source:
  - `hold`, if `hold_full`;
  - `i_data`, if a handshake occurs on this edge with `hold` empty (bypass);
  - `IDLE_WORD`, otherwise.
  - If `hold` drains and a handshake occurs on the same edge, the new word enters `hold`.
- **Non-load edge:**
  - Shift registers shift right by OUT_BITS.
  - An accepted word enters `hold` and sets `hold_full`.
- **Underrun and priming**
  - `primed` sets on the first accepted word.
  - An IDLE_WORD load while `primed` sets `o_underrun`.
  - If set and clear occur on the same edge, set wins.
  - `primed` stays 1 until reset.
- **Output slice:** `o_data` per channel = `shift[OUT_BITS-1:0]` (LSB first). Within a slice, bit k carries word bit `(beat*OUT_BITS + k)`.
- **`o_word_start`:** registered; 1 in the cycle after each load edge.

## Timing
- **Reset values:**
  - `o_data` = 0, `o_word_start` = 0, `o_underrun` = 0.
  - `o_ready` = 1.
  - `cnt` = 0, `hold_full` = 0, `primed` = 0, shift registers = 0.
- **Startup:** the first load edge is the BEATS-th edge after reset release. With no data, it loads IDLE_WORD and does not flag an underrun.
- **Latency:**
  - Bypass load: first slice appears on `o_data` 1 cycle after acceptance.
  - Otherwise: the word appears on the cycle after the next load edge (at most BEATS cycles).
- **Throughput:** with `i_valid` held high, the output is back-to-back words. `o_ready` pulses high on the load cycle once `hold` is full.
- **Mid-operation reset:** asserting `i_rst_n` low immediately clears all state, including the partially shifted word and the held word. No partial word is replayed after release.
- **`i_valid` low:** `i_data` is ignored. The block never stalls its output: the output rate is fixed at one slice per clock.

## Configuration
- **`SERIALIZER_MSB_FIRST_EN`**
  - Defined: the slice is `shift[WIDTH-1 -: OUT_BITS]` and the shift is left by OUT_BITS. The word MSB leaves first, and within a slice the higher-numbered word bits sit in higher `o_data` bits.
  - Undefined: LSB first, as described above (TMDS order).

## Test plan
- **Reset:** CHANNELS=3, WIDTH=10, OUT_BITS=1; hold `i_rst_n`=0 → `o_data`=3'b000, `o_ready`=1, `o_word_start`=0, `o_underrun`=0. After release, the first 10 output cycles of each channel carry IDLE_WORD and `o_underrun` stays 0.
- **Single word:** send ch0=10'b0110100110, ch1=10'b1001011001, ch2=10'b1100000010 → ch0 emits 0,1,1,0,0,1,0,1,1,0, and ch1/ch2 match bitwise LSB first. `o_word_start`=1 only on the first bit.
- **Continuous stream:** `i_valid`=1 for 8 words → 80 contiguous bits with no IDLE_WORD and `o_underrun`=0. Check `o_ready` timing against the rule above.
- **Underrun:** after 2 words, drop `i_valid` → the next 10 bits per channel = 10'b1101010100 and `o_underrun`=1. Pulse `i_clear_underrun` → 0. Assert clear on an underrun load edge → flag stays 1.
- **Gearbox:** OUT_BITS=2, word ch2=10'b1100000010 → slices 2'b10, 2'b00, 2'b00, 2'b00, 2'b11. With `SERIALIZER_MSB_FIRST_EN` → 2'b11, 2'b00, 2'b00, 2'b00, 2'b10.
- **Reset mid-word:** assert `i_rst_n`=0 at beat 4 with `hold` full → all outputs read reset values within the same cycle. After release, neither the remaining bits nor the held word appear, and IDLE_WORD follows.
